// File: rtl/tetris_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : tetris_seq_if
// Brief    : Bundle between the tetris sequencer and the rng/clear_redraw
//            datapath; slave is the sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface tetris_seq_if;
    logic [1:0]  move;
    logic [1:0]  piece_in;
    logic [31:0] board;
    logic        error;
    logic [2:0]  state;
    logic [1:0]  curr_piece;
    logic [4:0]  location;
    logic [2:0]  row_sel;
    logic        game_over;
    logic [7:0]  lines;

    modport slave (
        input  move, piece_in, board, error,
        output state, curr_piece, location, row_sel, game_over, lines
    );

    modport master (
        output move, piece_in, board, error,
        input  state, curr_piece, location, row_sel, game_over, lines
    );
endinterface
`default_nettype wire

// File: rtl/tetris_seq.sv
`default_nettype none
// ============================================================================
// Module   : tetris_seq
// Brief    : Game sequencer FSM: spawn, gravity/side moves, collision undo,
//            lock and one-at-a-time row clearing. Define TETRIS_SEQ_LINES_EN
//            to build the saturating cleared-lines counter.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_seq #(
    parameter int unsigned DROP_DIV  = 4,
    parameter logic [4:0]  SPAWN_LOC = 5'd28
) (
    input  wire logic   clka,
    input  wire logic   restart_n,
    tetris_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_CLR      = 3'd0,
        S_SPAWN    = 3'd1,
        S_FALL     = 3'd2,
        S_CHECK    = 3'd3,
        S_LOCK     = 3'd4,
        S_LINECHK  = 3'd5,
        S_ROWCLR   = 3'd6,
        S_GAMEOVER = 3'd7
    } state_t;

    localparam logic [7:0] c_drop_last = 8'(DROP_DIV - 1);
    localparam logic [1:0] c_mv_left   = 2'b01;
    localparam logic [1:0] c_mv_right  = 2'b10;
    localparam logic [1:0] c_mv_drop   = 2'b11;

    state_t     r_state,   w_state_nxt;
    logic [1:0] r_piece,   w_piece_nxt;
    logic [4:0] r_loc,     w_loc_nxt;
    logic [4:0] r_prev,    w_prev_nxt;
    logic [2:0] r_row_sel, w_row_sel_nxt;
    logic [7:0] r_cnt,     w_cnt_nxt;
    logic       r_fast,    w_fast_nxt;
    logic       r_first,   w_first_nxt;
    logic       r_op_drop, w_op_drop_nxt;
    logic       w_tick;
    logic       w_full_found;
    logic [2:0] w_full_row;

    // Descending scan so the lowest full row is the one left standing.
    always_comb begin
        w_full_found = 1'b0;
        w_full_row   = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            if (bus.board[4*r +: 4] == 4'hF) begin
                w_full_found = 1'b1;
                w_full_row   = 3'(r);
            end
        end
    end

    assign w_tick = r_fast || (r_cnt == c_drop_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_piece_nxt   = r_piece;
        w_loc_nxt     = r_loc;
        w_prev_nxt    = r_prev;
        w_row_sel_nxt = r_row_sel;
        w_cnt_nxt     = r_cnt;
        w_fast_nxt    = r_fast;
        w_first_nxt   = r_first;
        w_op_drop_nxt = r_op_drop;
        case (r_state)
            S_CLR: w_state_nxt = S_SPAWN;
            S_SPAWN: begin
                w_piece_nxt = bus.piece_in;
                w_loc_nxt   = SPAWN_LOC;
                w_cnt_nxt   = 8'd0;
                w_fast_nxt  = 1'b0;
                w_first_nxt = 1'b1;
                w_state_nxt = S_FALL;
            end
            S_FALL: begin
                w_first_nxt = 1'b0;
                if (r_first && bus.error) begin
                    w_state_nxt = S_GAMEOVER;
                end else if (w_tick) begin
                    // Gravity wins over any player request this cycle.
                    w_cnt_nxt = 8'd0;
                    if (r_loc[4:2] == 3'd0) begin
                        w_state_nxt = S_LOCK;
                    end else begin
                        w_prev_nxt    = r_loc;
                        w_loc_nxt     = r_loc - 5'd4;
                        w_op_drop_nxt = 1'b1;
                        w_state_nxt   = S_CHECK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    case (bus.move)
                        c_mv_left: begin
                            if (r_loc[1:0] != 2'd0) begin
                                w_prev_nxt    = r_loc;
                                w_loc_nxt     = r_loc - 5'd1;
                                w_op_drop_nxt = 1'b0;
                                w_state_nxt   = S_CHECK;
                            end
                        end
                        c_mv_right: begin
                            if (r_loc[1:0] != 2'd3) begin
                                w_prev_nxt    = r_loc;
                                w_loc_nxt     = r_loc + 5'd1;
                                w_op_drop_nxt = 1'b0;
                                w_state_nxt   = S_CHECK;
                            end
                        end
                        c_mv_drop: w_fast_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_CHECK: begin
                if (bus.error) begin
                    w_loc_nxt   = r_prev;
                    w_state_nxt = r_op_drop ? S_LOCK : S_FALL;
                end else begin
                    w_state_nxt = S_FALL;
                end
            end
            S_LOCK: w_state_nxt = S_LINECHK;
            S_LINECHK: begin
                if (w_full_found) begin
                    w_row_sel_nxt = w_full_row;
                    w_state_nxt   = S_ROWCLR;
                end else begin
                    w_state_nxt = S_SPAWN;
                end
            end
            S_ROWCLR:   w_state_nxt = S_LINECHK;
            S_GAMEOVER: w_state_nxt = S_GAMEOVER;
            default:    w_state_nxt = S_CLR;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state <= S_CLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_piece   <= 2'd0;
            r_loc     <= SPAWN_LOC;
            r_prev    <= SPAWN_LOC;
            r_row_sel <= 3'd0;
            r_cnt     <= 8'd0;
            r_fast    <= 1'b0;
            r_first   <= 1'b0;
            r_op_drop <= 1'b0;
        end else begin
            r_piece   <= w_piece_nxt;
            r_loc     <= w_loc_nxt;
            r_prev    <= w_prev_nxt;
            r_row_sel <= w_row_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fast    <= w_fast_nxt;
            r_first   <= w_first_nxt;
            r_op_drop <= w_op_drop_nxt;
        end
    end

`ifdef TETRIS_SEQ_LINES_EN
    logic [7:0] r_lines;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_lines <= 8'd0;
        end else if ((r_state == S_ROWCLR) && (r_lines != 8'hFF)) begin
            r_lines <= r_lines + 8'd1;
        end
    end

    assign bus.lines = r_lines;
`else
    assign bus.lines = 8'd0;
`endif

    assign bus.state      = r_state;
    assign bus.curr_piece = r_piece;
    assign bus.location   = r_loc;
    assign bus.row_sel    = r_row_sel;
    assign bus.game_over  = (r_state == S_GAMEOVER);

endmodule
`default_nettype wire

// File: tb/tb_tetris_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_seq
// Brief    : Directed bench for tetris_seq with a row/column game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_seq;
    localparam int         DROP_DIV  = 4;
    localparam logic [4:0] SPAWN_LOC = 5'd28;
`ifdef TETRIS_SEQ_LINES_EN
    localparam int LINES_ON = 1;
`else
    localparam int LINES_ON = 0;
`endif

    logic clka;
    logic restart_n;
    tetris_seq_if bus ();

    tetris_seq #(.DROP_DIV(DROP_DIV), .SPAWN_LOC(SPAWN_LOC)) dut (
        .clka      (clka),
        .restart_n (restart_n),
        .bus       (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Game model: piece tracked as row/column, phases named by the game step.
    int m_phase, m_piece, m_row, m_col, m_prev_row, m_prev_col;
    int m_wait, m_row_sel, m_lines, m_full;
    bit m_fast, m_fresh, m_dropping, m_tick;

    function automatic int lowest_full(input logic [31:0] b);
        for (int r = 0; r < 8; r++)
            if (b[4*r +: 4] == 4'hF) return r;
        return -1;
    endfunction

    always @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            m_phase = 0; m_piece = 0;
            m_row = int'(SPAWN_LOC) / 4; m_col = int'(SPAWN_LOC) % 4;
            m_prev_row = m_row; m_prev_col = m_col;
            m_wait = 0; m_fast = 0; m_fresh = 0; m_dropping = 0;
            m_row_sel = 0; m_lines = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    m_piece = int'(bus.piece_in);
                    m_row = int'(SPAWN_LOC) / 4; m_col = int'(SPAWN_LOC) % 4;
                    m_wait = 0; m_fast = 0; m_fresh = 1; m_phase = 2;
                end
                2: begin
                    m_tick = m_fast || (m_wait == DROP_DIV - 1);
                    if (m_fresh && bus.error) begin
                        m_phase = 7;
                    end else if (m_tick) begin
                        m_wait = 0;
                        if (m_row == 0) m_phase = 4;
                        else begin
                            m_prev_row = m_row; m_prev_col = m_col;
                            m_row--; m_dropping = 1; m_phase = 3;
                        end
                    end else begin
                        m_wait++;
                        if (bus.move == 2'd1 && m_col > 0) begin
                            m_prev_row = m_row; m_prev_col = m_col;
                            m_col--; m_dropping = 0; m_phase = 3;
                        end else if (bus.move == 2'd2 && m_col < 3) begin
                            m_prev_row = m_row; m_prev_col = m_col;
                            m_col++; m_dropping = 0; m_phase = 3;
                        end else if (bus.move == 2'd3) begin
                            m_fast = 1;
                        end
                    end
                    m_fresh = 0;
                end
                3: begin
                    if (bus.error) begin
                        m_row = m_prev_row; m_col = m_prev_col;
                        m_phase = m_dropping ? 4 : 2;
                    end else m_phase = 2;
                end
                4: m_phase = 5;
                5: begin
                    m_full = lowest_full(bus.board);
                    if (m_full >= 0) begin m_row_sel = m_full; m_phase = 6; end
                    else m_phase = 1;
                end
                6: begin
                    if (LINES_ON == 1 && m_lines < 255) m_lines++;
                    m_phase = 5;
                end
                default: m_phase = 7;
            endcase
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        check("m_state",      32'(bus.state),      m_phase);
        check("m_curr_piece", 32'(bus.curr_piece), m_piece);
        check("m_location",   32'(bus.location),   m_row * 4 + m_col);
        check("m_row_sel",    32'(bus.row_sel),    m_row_sel);
        check("m_game_over",  32'(bus.game_over),  (m_phase == 7) ? 1 : 0);
        check("m_lines",      32'(bus.lines),      m_lines);
    endtask

    task automatic step();
        @(posedge clka);
        @(negedge clka);
        cmp_model();
    endtask

    task automatic run_until(input logic [2:0] target, input int budget);
        int n = 0;
        while (bus.state !== target && n < budget) begin
            step();
            n++;
        end
        check("reach_state", 32'(bus.state), 32'(target));
    endtask

    int n_steps, n_chk;

    initial begin
        restart_n = 1'b1;
        bus.move = 2'd0; bus.piece_in = 2'd2; bus.board = 32'h0; bus.error = 1'b0;
        #2 restart_n = 1'b0;
        @(negedge clka);
        cmp_model();
        check("rst_state", 32'(bus.state), 0);
        check("rst_loc",   32'(bus.location), 28);
        check("rst_lines", 32'(bus.lines), 0);
        restart_n = 1'b1;

        // Spawn and plain gravity descent
        step(); check("seq_spawn", 32'(bus.state), 1);
        step(); check("seq_fall",  32'(bus.state), 2);
        check("spawn_loc", 32'(bus.location), 28);
        check("spawn_piece", 32'(bus.curr_piece), 2);
        repeat (3) step();
        check("grav_wait", 32'(bus.state), 2);
        step();
        check("grav_check", 32'(bus.state), 3);
        check("grav_loc", 32'(bus.location), 24);
        run_until(3'd4, 60);
        check("lock_loc", 32'(bus.location), 0);
        run_until(3'd1, 5);
        step();

        // Side moves, column guards and collision undo
        bus.move = 2'd1; step();
        check("left_col0_state", 32'(bus.state), 2);
        check("left_col0_loc", 32'(bus.location), 28);
        bus.move = 2'd2; step();
        check("right_state", 32'(bus.state), 3);
        check("right_loc", 32'(bus.location), 29);
        bus.move = 2'd0; step();
        check("right_back", 32'(bus.state), 2);
        bus.move = 2'd2; step();
        bus.move = 2'd0; step();
        step();
        check("tick_loc", 32'(bus.location), 26);
        step();
        bus.move = 2'd2; step();
        bus.move = 2'd0; step();
        bus.move = 2'd2; step();
        check("right_col3_state", 32'(bus.state), 2);
        check("right_col3_loc", 32'(bus.location), 27);
        bus.move = 2'd1; step();
        check("left_loc", 32'(bus.location), 26);
        bus.move = 2'd0; bus.error = 1'b1; step();
        check("side_undo_state", 32'(bus.state), 2);
        check("side_undo_loc", 32'(bus.location), 27);
        bus.error = 1'b0; step();
        check("drop_loc", 32'(bus.location), 23);
        bus.error = 1'b1; step();
        check("drop_undo_state", 32'(bus.state), 4);
        check("drop_undo_loc", 32'(bus.location), 27);
        bus.error = 1'b0; step();
        check("linechk", 32'(bus.state), 5);

        // Two full rows at the bottom, datapath shift emulated by the bench
        bus.board = 32'h0000_00FF; step();
        check("rowclr_a", 32'(bus.state), 6);
        check("rowsel_a", 32'(bus.row_sel), 0);
        bus.board = 32'h0000_000F; step();
        step();
        check("rowclr_b", 32'(bus.state), 6);
        check("rowsel_b", 32'(bus.row_sel), 0);
        bus.board = 32'h0; step(); step();
        check("after_clear", 32'(bus.state), 1);
        check("lines_two", 32'(bus.lines), 32'(2 * LINES_ON));

        // Hard drop: one CHECK every second cycle
        bus.piece_in = 2'd3; step();
        check("spawn_piece3", 32'(bus.curr_piece), 3);
        bus.move = 2'd3; step();
        check("hard_arm", 32'(bus.state), 2);
        bus.move = 2'd0; n_steps = 0; n_chk = 0;
        while (bus.state !== 3'd4 && n_steps < 40) begin
            step();
            n_steps++;
            if (bus.state === 3'd3) n_chk++;
        end
        check("hard_cycles", n_steps, 15);
        check("hard_checks", n_chk, 7);

        // Full rows 1 and 3, lowest cleared first
        step();
        bus.board = 32'h0000_F0F0; step();
        check("rowsel_f0f0_a", 32'(bus.row_sel), 1);
        bus.board = 32'h0000_0F00; step(); step();
        check("rowsel_f0f0_b", 32'(bus.row_sel), 2);
        bus.board = 32'h0; step(); step();
        check("lines_four", 32'(bus.lines), 32'(4 * LINES_ON));

        // Blocked spawn and reset out of GAMEOVER
        bus.error = 1'b1; step(); step();
        check("gameover_state", 32'(bus.state), 7);
        check("gameover_flag", 32'(bus.game_over), 1);
        bus.move = 2'd3;
        repeat (6) step();
        check("gameover_hold", 32'(bus.state), 7);
        #2 restart_n = 1'b0;
        #1;
        cmp_model();
        check("abort_state", 32'(bus.state), 0);
        check("abort_lines", 32'(bus.lines), 0);
        check("abort_loc", 32'(bus.location), 28);
        bus.move = 2'd0; bus.error = 1'b0;
        #1 restart_n = 1'b1;
        check("release_state", 32'(bus.state), 0);
        step();
        check("restart_spawn", 32'(bus.state), 1);
        step(); step();
        check("restart_fall", 32'(bus.state), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
